// File: rtl/barrel_shifter_pipe.sv
// Two-stage pipelined barrel shifter: logical/arithmetic/rotate/fill-bit shifts, left or right.
// Latency: 2 cycles from accept to out_valid; one operation per cycle while out_ready stays high.
// Backpressure: a stalled S2 stalls S1; in_ready follows out_ready combinationally and holds outputs stable.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             operation handshake
//   in_data, in_amt, in_dir       operand, shift amount (0..WIDTH-1), direction (0 left, 1 right)
//   in_mode, in_fill              00 logical, 01 arithmetic, 10 rotate, 11 fill-bit; fill value for mode 11
//   out_valid/out_ready           result handshake
//   out_data, out_carry, out_zero shifted result, last bit shifted out, result-is-zero flag
//   op_count                      completed output transfers, saturating (only with SHIFTER_STATS_EN)
//
// Optional feature macro: SHIFTER_STATS_EN adds the op_count output and its counter.

module barrel_shifter_pipe #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic                     in_dir,
    input  logic [1:0]               in_mode,
    input  logic                     in_fill,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_carry,
    output logic                     out_zero
`ifdef SHIFTER_STATS_EN
    ,
    output logic [15:0]              op_count
`endif
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        MODE_LOG = 2'b00,
        MODE_ARI = 2'b01,
        MODE_ROT = 2'b10,
        MODE_FIL = 2'b11
    } mode_t;

    // S1: registered operation
    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [SHW-1:0]   s1_amt;
    logic             s1_dir;
    mode_t            s1_mode;
    logic             s1_fill;

    // S2: registered result (drives the output ports directly)
    logic             s2_valid;

    // Held low through reset and released by the first clock edge afterwards,
    // so in_ready cannot rise asynchronously when rst drops.
    logic             ready_en;

    logic             s1_adv;
    logic             accept;

    assign s1_adv    = !s2_valid || out_ready;
    assign in_ready  = ready_en && (!s1_valid || s1_adv);
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_amt   <= '0;
            s1_dir   <= 1'b0;
            s1_mode  <= MODE_LOG;
            s1_fill  <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_data <= in_data;
                s1_amt  <= in_amt;
                s1_dir  <= in_dir;
                s1_mode <= mode_t'(in_mode);
                s1_fill <= in_fill;
            end
        end
    end

    // Shift datapath between S1 and S2.
    logic [SHW-1:0]   neg_amt;   // (WIDTH - amt) mod WIDTH
    logic [SHW-1:0]   amt_m1;
    logic [SHW-1:0]   rot_k;     // rotate expressed as a right rotate by rot_k
    logic [SHW:0]     rot_l;     // WIDTH - rot_k; equals WIDTH when rot_k is 0, giving an all-zero term
    logic             vac_bit;
    logic [WIDTH-1:0] vac_mask;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] rotated;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;

    always_comb begin
        neg_amt   = '0 - s1_amt;
        amt_m1    = s1_amt - 1'b1;
        rot_k     = s1_dir ? s1_amt : neg_amt;
        rot_l     = WIDTH[SHW:0] - {1'b0, rot_k};
        rotated   = (s1_data >> rot_k) | (s1_data << rot_l);

        vac_bit = 1'b0;
        case (s1_mode)
            MODE_ARI: vac_bit = s1_dir & s1_data[WIDTH-1];
            MODE_FIL: vac_bit = s1_fill;
            default:  vac_bit = 1'b0;
        endcase

        if (s1_dir) begin
            shifted  = s1_data >> s1_amt;
            vac_mask = ~({WIDTH{1'b1}} >> s1_amt);
        end else begin
            shifted  = s1_data << s1_amt;
            vac_mask = ~({WIDTH{1'b1}} << s1_amt);
        end

        if (s1_mode == MODE_ROT) begin
            res_data = rotated;
        end else begin
            res_data = shifted | (vac_bit ? vac_mask : '0);
        end

        // Last bit out: data[amt-1] going right, data[WIDTH-amt] going left.
        if (s1_amt == '0) begin
            res_carry = 1'b0;
        end else if (s1_dir) begin
            res_carry = s1_data[amt_m1];
        end else begin
            res_carry = s1_data[neg_amt];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data  <= res_data;
                out_carry <= res_carry;
                out_zero  <= (res_data == '0);
            end
        end
    end

`ifdef SHIFTER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (out_valid && out_ready && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe at WIDTH=16: directed vector table,
// backpressure and reset-in-flight sequences, then randomized traffic against a
// bit-level reference model with an in-order scoreboard.

module tb_barrel_shifter_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [3:0]  in_amt = '0;
    logic        in_dir = 1'b0;
    logic [1:0]  in_mode = '0;
    logic        in_fill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_carry;
    logic        out_zero;
`ifdef SHIFTER_STATS_EN
    logic [15:0] op_count;
`endif

    barrel_shifter_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_mode   (in_mode),
        .in_fill   (in_fill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero)
`ifdef SHIFTER_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        zero;
        logic        carry;
        logic [15:0] data;
    } res_t;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  a;
        logic        dir;
        logic [1:0]  mode;
        logic        fill;
        logic [15:0] xd;
        logic        xc;
        logic        xz;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: each output bit is picked from its source position; out-of-range
    // sources take the vacated value for the mode, or wrap when rotating.
    function automatic res_t model(input logic [15:0] d, input logic [3:0] a,
                                   input logic dir, input logic [1:0] mode, input logic fill);
        res_t r;
        int   k;
        int   src;
        k = int'(a);
        r.data = '0;
        for (int i = 0; i < 16; i++) begin
            src = dir ? i + k : i - k;
            if (src >= 0 && src < 16) begin
                r.data[i] = d[src];
            end else begin
                case (mode)
                    2'b10:   r.data[i] = d[(src + 16) % 16];
                    2'b11:   r.data[i] = fill;
                    2'b01:   r.data[i] = dir ? d[15] : 1'b0;
                    default: r.data[i] = 1'b0;
                endcase
            end
        end
        if (k == 0)   r.carry = 1'b0;
        else if (dir) r.carry = d[k-1];
        else          r.carry = d[16-k];
        r.zero = (r.data == 16'h0000);
        return r;
    endfunction

    task automatic drive(input vec_t v);
        in_data = v.d;
        in_amt  = v.a;
        in_dir  = v.dir;
        in_mode = v.mode;
        in_fill = v.fill;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t outs();
        res_t r;
        r.data  = out_data;
        r.carry = out_carry;
        r.zero  = out_zero;
        return r;
    endfunction

    vec_t vecs[12];
    vec_t bp[3];
    res_t exp_q[$];
    res_t held;
    res_t e;
    logic stalled_prev;

    initial begin
        //          data      amt  dir  mode   fill   exp_data  c     z
        vecs[0]  = '{16'h00F1, 4'd4,  1'b0, 2'b00, 1'b0, 16'h0F10, 1'b0, 1'b0};
        vecs[1]  = '{16'h8004, 4'd3,  1'b1, 2'b01, 1'b0, 16'hF000, 1'b1, 1'b0};
        vecs[2]  = '{16'h8001, 4'd1,  1'b0, 2'b10, 1'b0, 16'h0003, 1'b1, 1'b0};
        vecs[3]  = '{16'h0001, 4'd1,  1'b1, 2'b10, 1'b0, 16'h8000, 1'b1, 1'b0};
        vecs[4]  = '{16'h0000, 4'd15, 1'b1, 2'b11, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[5]  = '{16'h8000, 4'd1,  1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6]  = '{16'hA5A5, 4'd0,  1'b0, 2'b01, 1'b0, 16'hA5A5, 1'b0, 1'b0};
        vecs[7]  = '{16'h1234, 4'd0,  1'b1, 2'b11, 1'b1, 16'h1234, 1'b0, 1'b0};
        vecs[8]  = '{16'h0000, 4'd0,  1'b1, 2'b10, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[9]  = '{16'h1234, 4'd8,  1'b0, 2'b01, 1'b0, 16'h3400, 1'b0, 1'b0};
        vecs[10] = '{16'h0001, 4'd15, 1'b0, 2'b11, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[11] = '{16'hFFFF, 4'd15, 1'b1, 2'b00, 1'b0, 16'h0001, 1'b1, 1'b0};

        bp[0] = '{16'h00F1, 4'd4, 1'b0, 2'b00, 1'b0, 16'h0F10, 1'b0, 1'b0};
        bp[1] = '{16'h8004, 4'd3, 1'b1, 2'b01, 1'b0, 16'hF000, 1'b1, 1'b0};
        bp[2] = '{16'h8001, 4'd1, 1'b0, 2'b10, 1'b0, 16'h0003, 1'b1, 1'b0};

        // ---------------- reset state ----------------
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outs", 32'(outs()), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rdy_before_edge", 32'(in_ready), 32'd0);
        step();
        check("rdy_after_edge", 32'(in_ready), 32'd1);

        // ---------------- directed vector table ----------------
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            step();
            in_valid = 1'b0;
            check($sformatf("v%0d_lat1_valid", i), 32'(out_valid), 32'd0);
            step();
            check($sformatf("v%0d_lat2_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].xd));
            check($sformatf("v%0d_carry", i), 32'(out_carry), 32'(vecs[i].xc));
            check($sformatf("v%0d_zero", i), 32'(out_zero), 32'(vecs[i].xz));
        end
        step();
        check("table_drained", 32'(out_valid), 32'd0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        drive(bp[0]); in_valid = 1'b1; #1;
        check("bp_acc0", 32'(in_ready), 32'd1);
        step();
        drive(bp[1]); #1;
        check("bp_acc1", 32'(in_ready), 32'd1);
        step();
        drive(bp[2]); #1;
        check("bp_full", 32'(in_ready), 32'd0);
        step();
        check("bp_full_still", 32'(in_ready), 32'd0);
        check("bp_stall_valid", 32'(out_valid), 32'd1);
        check("bp_stall_data", 32'(out_data), 32'(bp[0].xd));
        held = outs();
        step();
        check("bp_hold", 32'(outs()), 32'(held));
        out_ready = 1'b1; #1;
        check("bp_rdy_comb", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_out1_valid", 32'(out_valid), 32'd1);
        check("bp_out1_data", 32'(out_data), 32'(bp[1].xd));
        check("bp_out1_carry", 32'(out_carry), 32'(bp[1].xc));
        step();
        check("bp_out2_valid", 32'(out_valid), 32'd1);
        check("bp_out2_data", 32'(out_data), 32'(bp[2].xd));
        check("bp_out2_carry", 32'(out_carry), 32'(bp[2].xc));
        step();
        check("bp_drained", 32'(out_valid), 32'd0);

        // ---------------- reset with operations in flight ----------------
        drive(vecs[0]); in_valid = 1'b1;
        step();
        drive(vecs[1]);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check("inflight_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_outs", 32'(outs()), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("post_rst_quiet%0d", i), 32'(out_valid), 32'd0);
        end

`ifdef SHIFTER_STATS_EN
        check("op_count_reset", 32'(op_count), 32'd0);
        drive(vecs[2]); in_valid = 1'b1;
        step();
        drive(vecs[3]);
        step();
        in_valid = 1'b0;
        step();
        check("op_count_one", 32'(op_count), 32'd1);
        step();
        check("op_count_two", 32'(op_count), 32'd2);
`endif

        // ---------------- randomized traffic ----------------
        exp_q.delete();
        stalled_prev = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            step();
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            in_data   = 16'($urandom);
            in_amt    = 4'($urandom);
            in_dir    = 1'($urandom);
            in_mode   = 2'($urandom);
            in_fill   = 1'($urandom);
            #1;
            if (stalled_prev) begin
                check("rnd_stall_valid", 32'(out_valid), 32'd1);
                check("rnd_stall_hold", 32'(outs()), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_out", 32'd1, 32'(exp_q.size()));
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_result", 32'(outs()), 32'(e));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data, in_amt, in_dir, in_mode, in_fill));
            end
            stalled_prev = out_valid && !out_ready;
            held = outs();
        end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
            #1;
            if (out_valid) begin
                e = exp_q.pop_front();
                check("drain_result", 32'(outs()), 32'(e));
            end
            step();
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        #1;
        check("drain_idle", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
